// File: rtl/apb_master_param.sv
// rtl/apb_master_param.sv - APB4 master converting a valid/ready command into SETUP/ACCESS transfers
// Optional wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_param #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                Pclk,
    input  logic                Prst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_complete;
    logic   w_timeout;
    logic   w_done;
    logic   w_accept;

    assign w_complete = (r_state == S_ACCESS) && PREADY;
    assign cmd_ready  = (r_state == S_IDLE) || w_complete;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_done     = w_complete || w_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive PREADY-low ACCESS cycle
    assign w_timeout = (r_state == S_ACCESS) && !PREADY
                       && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_ACCESS) && !PREADY && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    // Never true; ACCESS waits for PREADY indefinitely in this build
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                PSEL        = 1'b1;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else if (w_complete) begin
                    w_state_nxt = w_accept ? S_SETUP : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer fields only change on an accept edge and hold otherwise
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            PSTRB  <= '0;
        end else if (w_accept) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
            PSTRB  <= cmd_write ? cmd_strb : '0;
        end
    end

    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= w_done;
            if (w_done) begin
                rsp_err   <= w_timeout ? 1'b1 : PSLVERR;
                rsp_rdata <= (PWRITE || w_timeout) ? '0 : PRDATA;
            end
        end
    end

endmodule

// File: doc/apb_master_param.md
# apb_master_param

Parametrised APB4 master. Converts a single-entry valid/ready command interface into APB SETUP/ACCESS transfers, with configurable address/data width, PREADY wait states, PSLVERR capture and back-to-back transfers. Sits between a local controller or sequencer and an APB slave or decoder. Returns read data and error status as a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 32: address width; ≥ 2.
- DATA_W, 32: data width; multiple of 8, range 8..64.
- TIMEOUT_CYCLES, 16: wait-state limit, used only with the timeout feature; ≥ 1, counter width $clog2(TIMEOUT_CYCLES+1).

Ports:
- Pclk in 1: clock, rising edge.
- Prst in 1: reset, asynchronous, active-low.
- cmd_valid in 1: command present.
- cmd_ready out 1: master can accept a command.
- cmd_write in 1: 1 = write, 0 = read.
- cmd_addr in ADDR_W: transfer address.
- cmd_wdata in DATA_W: write data.
- cmd_strb in DATA_W/8: write byte strobes.
- PADDR out ADDR_W: APB address.
- PSEL out 1: APB select.
- PENABLE out 1: APB enable.
- PWRITE out 1: APB direction.
- PWDATA out DATA_W: APB write data.
- PSTRB out DATA_W/8: APB strobes; forced to 0 on reads.
- PRDATA in DATA_W: slave read data.
- PREADY in 1: slave ready, active-high.
- PSLVERR in 1: slave error, sampled only at completion.
- rsp_valid out 1: one-cycle completion pulse.
- rsp_rdata out DATA_W: captured PRDATA for reads; 0 for writes.
- rsp_err out 1: PSLVERR captured at completion, or timeout.

## Operation
- State machine: IDLE, SETUP, ACCESS. Reset state is IDLE.
- Completion is defined as ACCESS && PREADY.
- cmd_ready = (state == IDLE) || completion. It is combinational from state and PREADY.
- Accept occurs when cmd_valid && cmd_ready. Command fields are registered into PADDR, PWRITE, PWDATA and PSTRB on the accept edge.
- Transitions:
  - IDLE → SETUP on accept; otherwise stay in IDLE.
  - SETUP → ACCESS unconditionally.
  - ACCESS with !PREADY → ACCESS.
  - ACCESS with completion and accept → SETUP (back-to-back; PSEL stays high).
  - ACCESS with completion and no accept → IDLE.
- Outputs by state:
  - PSEL = 1 in SETUP and ACCESS.
  - PENABLE = 1 in ACCESS only.
- PADDR, PWRITE, PWDATA and PSTRB hold stable from SETUP through the completion cycle. They change only on an accept edge and retain their values in IDLE.
- Response:
  - On the completion edge, register rsp_valid=1 and rsp_err=PSLVERR.
  - Register rsp_rdata = PWRITE ? 0 : PRDATA.
  - rsp_valid is high for exactly one cycle. There is no back-pressure; the consumer must take the response.
  - rsp_rdata and rsp_err hold until the next response.
- Reset values (asynchronous, any state):
  - state = IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_err = 0.
  - PADDR, PWDATA, PSTRB, rsp_rdata = 0.
  - A transfer in progress is abandoned and no response is issued.

## Timing
- Accept at edge N gives SETUP in cycle N..N+1 and ACCESS from edge N+1.
- With PREADY high in the first ACCESS cycle, completion is at edge N+2 and rsp_valid is high in cycle N+2..N+3.
- Minimum latency from accept to rsp_valid is 2 cycles, plus 1 cycle per PREADY-low ACCESS cycle.
- Back-to-back throughput is one transfer per 2 cycles. PSEL never deasserts between chained transfers.
- PSLVERR and PRDATA are ignored outside completion cycles.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY low.
  - When the count reaches TIMEOUT_CYCLES with PREADY still low, the transfer is force-completed. It behaves as a completion with rsp_err=1 and rsp_rdata=0, and the next state is IDLE (no chaining on a timeout).
- Without the macro: no counter logic exists, and ACCESS waits indefinitely for PREADY.

## Test plan
- **Single write, no waits.** Write at addr 0xA000, data 0x1234_5678, strb 0xF, PREADY=1.
  Required: PSEL high for 2 cycles, PENABLE in the 2nd; rsp_valid 2 cycles after accept with rsp_err=0, rsp_rdata=0.
- **Read with waits.** Read at 0xA000, PREADY low for 3 ACCESS cycles, PRDATA=0xDEAD_BEEF at completion.
  Required: PADDR stable for 5 cycles; rsp_rdata=0xDEAD_BEEF; PSTRB=0 throughout.
- **Back-to-back.** Read 0x10 then write 0x14 with cmd_valid held, PREADY=1.
  Required: PSEL continuously high for 4 cycles, SETUP immediately follows the first completion, two rsp_valid pulses 2 cycles apart.
- **Slave error.** PSLVERR=1 asserted during a wait cycle, then 0 at completion.
  Required: rsp_err=0. PSLVERR=1 at completion: rsp_err=1.
- **Reset mid-ACCESS.** Prst low during a wait state.
  Required: PSEL, PENABLE and rsp_valid go to 0 immediately; IDLE after release; no response pulse.
- **Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4).** PREADY held low.
  Required: rsp_valid with rsp_err=1 after 4 wait cycles, then IDLE. Without the macro: still in ACCESS after 100 cycles.
